// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port bundle for imem_loader.
interface imem_loader_if #(
  parameter int DWIDTH = 32
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [DWIDTH-1:0] imem_addr;
  logic [DWIDTH-1:0] imem_data;
  logic              imem_we;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, imem_addr, imem_data, imem_we
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, imem_addr, imem_data, imem_we
  );
endinterface

// File: rtl/imem_loader.sv
// Framed little-endian byte-stream loader that fills instruction memory and holds
// the core in reset until a frame with a correct XOR checksum has been written.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LEN0  | waiting for word count low byte
// LEN1  | waiting for word count high byte, range check
// DATA  | collecting the 4 bytes of a word
// WRITE | one-cycle memory write of the assembled word
// CSUM  | waiting for checksum byte
// DONE  | frame good, core released
// ERR   | frame rejected, core held
module imem_loader #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  imem_loader_if.slave bus,
  output logic        core_hold_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] words_loaded_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << (AWIDTH - 2);

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        acc_q, acc_d;
  logic [23:0]       word_q, word_d;
  logic [15:0]       words_q, words_d;
  logic [DWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic [15:0]       len_full;
  logic [15:0]       words_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      len_q      <= '0;
      acc_q      <= '0;
      word_q     <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      ready_q    <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      word_q     <= word_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      ready_q    <= ready_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    acc_d      = acc_q;
    word_d     = word_q;
    words_d    = words_q;
    addr_d     = addr_q;
    data_d     = data_q;

    // ready_q mirrors "state is a receiving state", so it doubles as the accept qualifier
    xfer      = bus.byte_valid && ready_q;
    len_full  = {bus.byte_in, len_q[7:0]};
    words_inc = words_q + 16'd1;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d    = S_LEN0;
          words_d    = '0;
          acc_d      = '0;
          byte_cnt_d = '0;
        end
      end
      S_LEN0: begin
        if (xfer) begin
          len_d[7:0] = bus.byte_in;
          acc_d      = acc_q ^ bus.byte_in;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d[15:8] = bus.byte_in;
          acc_d       = acc_q ^ bus.byte_in;
          if (len_full == 16'd0 || {1'b0, len_full} > CAP) state_d = S_ERR;
          else                                             state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          acc_d      = acc_q ^ bus.byte_in;
          byte_cnt_d = byte_cnt_q + 2'd1;
          unique case (byte_cnt_q)
            2'd0: word_d[7:0]   = bus.byte_in;
            2'd1: word_d[15:8]  = bus.byte_in;
            2'd2: word_d[23:16] = bus.byte_in;
            default: begin
              data_d  = DWIDTH'({bus.byte_in, word_q});
              addr_d  = DWIDTH'({words_q, 2'b00});
              state_d = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        words_d = words_inc;
        state_d = (words_inc == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (xfer) state_d = (bus.byte_in == acc_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up with state_q
    ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
              (state_d == S_DATA) || (state_d == S_CSUM);
    we_d    = (state_d == S_WRITE);
    hold_d  = (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
  end

  assign bus.byte_ready  = ready_q;
  assign bus.imem_addr   = addr_q;
  assign bus.imem_data   = data_q;
  assign bus.imem_we     = we_q;
  assign core_hold_o     = hold_q;
  assign done_o          = done_q;
  assign error_o         = err_q;
  assign words_loaded_o  = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of frames plus hand-written reset,
// start-ignore, reload and full-capacity sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader_if #(.DWIDTH(32)) bus ();

  imem_loader #(.AWIDTH(10), .DWIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .bus            (bus.slave),
    .core_hold_o    (core_hold),
    .done_o         (done),
    .error_o        (error),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  int          cap_cyc[$];
  logic        prev_we = 1'b0;

  typedef struct {
    logic [15:0]      n;
    logic [2:0][31:0] w;
    int               nw;
    logic [7:0]       cs;
    bit               gap;
    bit               exp_done;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      cap_addr.push_back(bus.imem_addr);
      cap_data.push_back(bus.imem_data);
      cap_cyc.push_back(cyc);
      chk("ready_low_in_write", 32'(bus.byte_ready), 32'd0);
      chk("we_single_cycle", 32'(prev_we), 32'd0);
    end
    prev_we <= bus.imem_we;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) @(negedge clk) bus.byte_valid = 1'b0;
    @(negedge clk);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    t = 0;
    while (bus.byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout actual=0 required=1");
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
  endtask

  task automatic run_frame(input logic [15:0] n, input logic [7:0] cs, input bit gap,
                           input bit do_start);
    if (do_start) begin
      cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
      pulse_start();
    end
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    foreach (exp_q[i]) send_word(exp_q[i], gap);
    if (exp_q.size() > 0) send_byte(cs, gap);
    @(negedge clk) bus.byte_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input bit exp_done);
    int t = 0;
    while (!(done === 1'b1 || error === 1'b1) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_end_within_bound"}, 32'(t < 40), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_error"}, 32'(error), 32'(!exp_done));
    chk({tag, "_core_hold"}, 32'(core_hold), 32'(!exp_done));
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(exp_q.size()));
    chk({tag, "_write_count"}, 32'(cap_addr.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({tag, "_addr"}, (i < cap_addr.size()) ? cap_addr[i] : 32'hxxxxxxxx, 32'(4 * i));
      chk({tag, "_data"}, (i < cap_data.size()) ? cap_data[i] : 32'hxxxxxxxx, exp_q[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_imem_addr"}, bus.imem_addr, 32'd0);
    chk({tag, "_imem_data"}, bus.imem_data, 32'd0);
    chk({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
    chk({tag, "_core_hold"}, 32'(core_hold), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] cs;
    logic [31:0] w;

    vecs[0] = '{16'd1,   {32'h0, 32'h0, 32'hDEADBEEF},               1, 8'h23, 1'b0, 1'b1};
    vecs[1] = '{16'd3,   {32'h00208113, 32'h00100093, 32'h00000013}, 3, 8'h21, 1'b1, 1'b1};
    vecs[2] = '{16'd1,   {32'h0, 32'h0, 32'hDEADBEEF},               1, 8'h24, 1'b0, 1'b0};
    vecs[3] = '{16'd0,   {32'h0, 32'h0, 32'h0},                      0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{16'd257, {32'h0, 32'h0, 32'h0},                      0, 8'h00, 1'b0, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      exp_q.delete();
      for (int i = 0; i < vecs[v].nw; i++) exp_q.push_back(vecs[v].w[i]);
      run_frame(vecs[v].n, vecs[v].cs, vecs[v].gap, 1'b1);
      check_result($sformatf("vec%0d", v), vecs[v].exp_done);
    end

    // reset after two of four payload bytes; imem_data still holds DEADBEEF here
    cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    chk("midrst_no_write", 32'(cap_addr.size()), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h12345678);
    run_frame(16'd1, 8'h09, 1'b0, 1'b1);
    check_result("after_rst", 1'b1);

    // start pulsed while collecting payload must be ignored
    exp_q.delete();
    exp_q.push_back(32'h11223344);
    exp_q.push_back(32'h55667788);
    cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h33, 1'b0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    send_byte(8'h22, 1'b0);
    send_byte(8'h11, 1'b0);
    send_word(32'h55667788, 1'b0);
    send_byte(8'h8A, 1'b0);
    @(negedge clk) bus.byte_valid = 1'b0;
    check_result("start_in_data", 1'b1);

    // reload from DONE re-asserts core_hold and clears done immediately
    cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
    pulse_start();
    chk("reload_core_hold", 32'(core_hold), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_byte_ready", 32'(bus.byte_ready), 32'd1);
    exp_q.delete();
    exp_q.push_back(32'hDEADBEEF);
    run_frame(16'd1, 8'h23, 1'b0, 1'b0);
    check_result("reload", 1'b1);

    // full capacity: 256 words, last address 0x3FC, 5 cycles per word
    exp_q.delete();
    cs = 8'h00 ^ 8'h01;
    for (int i = 0; i < 256; i++) begin
      w = 32'(i) * 32'h0001_0003 + 32'h1357_9BDF;
      exp_q.push_back(w);
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
    run_frame(16'd256, cs, 1'b0, 1'b1);
    check_result("n256", 1'b1);
    chk("n256_last_addr", (cap_addr.size() == 256) ? cap_addr[255] : 32'hxxxxxxxx, 32'h3FC);
    chk("n256_throughput", (cap_cyc.size() == 256) ? 32'(cap_cyc[255] - cap_cyc[0]) : 32'hxxxxxxxx,
        32'(255 * 5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
